ram512_arbiter: RTL

RAM512_ARBITER -- requirements
Module: ram512_arbiter

---
 rtl/ram512_arbiter_if.sv | 35 +++
 rtl/ram512_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/ram512_arbiter_if.sv
// Bus bundle between two requesters, the ram512_arbiter and a single-port async-read RAM.
// slave = arbiter side, master = requesters plus RAM model side.
interface ram512_arbiter_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
);
  logic                  aReq;
  logic                  bReq;
  logic                  aRw;
  logic                  bRw;
  logic [ADDR_WIDTH-1:0] aAddress;
  logic [ADDR_WIDTH-1:0] bAddress;
  logic [DATA_WIDTH-1:0] aDataIn;
  logic [DATA_WIDTH-1:0] bDataIn;
  logic [DATA_WIDTH-1:0] aDataOut;
  logic [DATA_WIDTH-1:0] bDataOut;
  logic                  aAck;
  logic                  bAck;
  logic [ADDR_WIDTH-1:0] ramAddress;
  logic                  ramSelect;
  logic                  ramRw;
  logic [DATA_WIDTH-1:0] ramDataIn;
  logic [DATA_WIDTH-1:0] ramDataOut;
  logic                  busy;

  modport slave (
    input  aReq, bReq, aRw, bRw, aAddress, bAddress, aDataIn, bDataIn, ramDataOut,
    output aDataOut, bDataOut, aAck, bAck, ramAddress, ramSelect, ramRw, ramDataIn, busy
  );

  modport master (
    output aReq, bReq, aRw, bRw, aAddress, bAddress, aDataIn, bDataIn, ramDataOut,
    input  aDataOut, bDataOut, aAck, bAck, ramAddress, ramSelect, ramRw, ramDataIn, busy
  );
endinterface

// File: rtl/ram512_arbiter.sv
// Two-port arbiter sequencing accesses to a 512-entry RAM with a registered strobe.
// Define RAM512_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed A priority.
//
// state   | meaning
// IDLE    | sample requests, grant one and latch its command onto the RAM bus
// SETUP   | RAM inputs settle, strobe low
// STROBE  | ramSelect high, RAM performs the access on its rising edge
// CAPTURE | strobe low, read data loaded into the granted port's register
// DONE    | Ack pulse to the granted port
module ram512_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
) (
  input logic               clock,
  input logic               resetN,
  ram512_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                  grant_go;
  logic                  pick_b;
  logic                  grant_b;
  logic                  ram_select_nxt;
  logic                  a_ack_nxt;
  logic                  b_ack_nxt;
  logic                  capture_a;
  logic                  capture_b;

  logic                  ram_select_q;
  logic                  ram_rw_q;
  logic [ADDR_WIDTH-1:0] ram_address_q;
  logic [DATA_WIDTH-1:0] ram_data_in_q;
  logic [DATA_WIDTH-1:0] a_data_out_q;
  logic [DATA_WIDTH-1:0] b_data_out_q;
  logic                  a_ack_q;
  logic                  b_ack_q;

`ifdef RAM512_ARB_ROUND_ROBIN_EN
  logic last_grant_b;
`endif

  always_comb begin
    grant_go = bus.aReq | bus.bReq;
`ifdef RAM512_ARB_ROUND_ROBIN_EN
    if (bus.aReq && bus.bReq) begin
      pick_b = ~last_grant_b;
    end else begin
      pick_b = bus.bReq;
    end
`else
    pick_b = ~bus.aReq;
`endif
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_go) state_nxt = SETUP;
      SETUP:   state_nxt = STROBE;
      STROBE:  state_nxt = CAPTURE;
      CAPTURE: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are computed one state ahead and registered so the strobe and acks are glitch-free.
  always_comb begin
    ram_select_nxt = (state == SETUP);
    a_ack_nxt      = (state == CAPTURE) && !grant_b;
    b_ack_nxt      = (state == CAPTURE) &&  grant_b;
    capture_a      = (state == CAPTURE) &&  ram_rw_q && !grant_b;
    capture_b      = (state == CAPTURE) &&  ram_rw_q &&  grant_b;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      ram_select_q  <= 1'b0;
      ram_rw_q      <= 1'b1;
      ram_address_q <= '0;
      ram_data_in_q <= '0;
      a_data_out_q  <= '0;
      b_data_out_q  <= '0;
      a_ack_q       <= 1'b0;
      b_ack_q       <= 1'b0;
      grant_b       <= 1'b0;
    end else begin
      ram_select_q <= ram_select_nxt;
      a_ack_q      <= a_ack_nxt;
      b_ack_q      <= b_ack_nxt;
      if (state == IDLE && grant_go) begin
        grant_b       <= pick_b;
        ram_rw_q      <= pick_b ? bus.bRw      : bus.aRw;
        ram_address_q <= pick_b ? bus.bAddress : bus.aAddress;
        ram_data_in_q <= pick_b ? bus.bDataIn  : bus.aDataIn;
      end
      if (capture_a) a_data_out_q <= bus.ramDataOut;
      if (capture_b) b_data_out_q <= bus.ramDataOut;
    end
  end

`ifdef RAM512_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      last_grant_b <= 1'b1;
    end else if (state == IDLE && grant_go) begin
      last_grant_b <= pick_b;
    end
  end
`endif

  assign bus.ramSelect  = ram_select_q;
  assign bus.ramRw      = ram_rw_q;
  assign bus.ramAddress = ram_address_q;
  assign bus.ramDataIn  = ram_data_in_q;
  assign bus.aDataOut   = a_data_out_q;
  assign bus.bDataOut   = b_data_out_q;
  assign bus.aAck       = a_ack_q;
  assign bus.bAck       = b_ack_q;
  assign bus.busy       = (state != IDLE);

endmodule
